dish_washer_plant_sensor: RTL and testbench
===========================================

# dish_washer_plant_sensor

Plant-side responder for the dish-washer sequencing controller. Consumes the controller's valve, door-lock and done commands and produces the sensor and timer handshakes the controller waits on: Filled, Drained, Detergent_Added, Washing_Timeout, Store_Timeout. It models the tank water level, the detergent dispenser, the wash timer and the store/dry timer. It closes the control loop in simulation and on FPGA bring-up without physical sensors.

## Interface
Parameters:
- LEVEL_W, 8, width of the water-level counter
- LEVEL_FULL, 16, level at which Filled asserts; must be greater than 0 and at most 2^LEVEL_W-1
- CNT_W, 16, width of all timer counters
- DET_CYCLES, 4, cycles spent dispensing detergent; must be at least 1
- WASH_CYCLES, 32, wash cycles before Washing_Timeout; must be at least 1
- STORE_CYCLES, 16, drained-and-draining cycles before Store_Timeout; must be at least 1

Ports:
- Clock  in  1  system clock; all state changes on the rising edge
- Reset  in  1  asynchronous, active-low reset
- Fill_valve_on  in  1  cold-fill valve command
- Fill_valve_second_on  in  1  wash (hot/spray) valve command
- Drained_valve_on  in  1  drain valve command
- Door_Lock  in  1  door locked; 0 means a cycle is not running
- Done  in  1  controller end-of-cycle indication
- Filled  out  1  Water_Level == LEVEL_FULL
- Drained  out  1  Water_Level == 0
- Detergent_Added  out  1  dispenser finished
- Washing_Timeout  out  1  wash timer expired
- Store_Timeout  out  1  store timer expired
- Water_Level  out  LEVEL_W  current modelled level
- Fault  out  1  sticky plant-misuse flag

## Operation
Clear condition:
- clr = Done | ~Door_Lock.

Water level (saturating register):
- Fill_valve_on=1 and Drained_valve_on=0: +1 per cycle, stops at LEVEL_FULL.
- Drained_valve_on=1 and Fill_valve_on=0: -1 per cycle, stops at 0.
- Both valves on: level holds and Fault sets.
- Neither valve on: level holds.
- Level is not affected by clr.

Filled and Drained:
- Combinational decodes of the Water_Level register.

Detergent FSM:
- D_IDLE -> D_DISPENSE when Door_Lock & Filled & ~Fill_valve_on.
- D_DISPENSE runs for exactly DET_CYCLES cycles (down-counter), then -> D_DONE.
- Detergent_Added = (state == D_DONE).
- Any state -> D_IDLE on clr.

Wash timer:
- wash_cnt +1 each cycle Fill_valve_second_on=1, saturating at WASH_CYCLES.
- Washing_Timeout = (wash_cnt == WASH_CYCLES).
- wash_cnt -> 0 on clr.

Store timer:
- store_cnt +1 each cycle Drained & Drained_valve_on & Washing_Timeout, saturating at STORE_CYCLES.
- Store_Timeout = (store_cnt == STORE_CYCLES).
- store_cnt -> 0 on clr.

Fault:
- Sets on both fill and drain valves on in the same cycle.
- Sets on Door_Lock=0 while Water_Level != 0.
- Cleared only by Reset.

## Timing
Reset values:
- Water_Level=0, Drained=1, Filled=0, Detergent_Added=0, Washing_Timeout=0, Store_Timeout=0, Fault=0.
- Detergent FSM in D_IDLE; all counters 0.
- Reset asserted mid-cycle returns everything to these values immediately, without waiting for a clock edge.

Latencies:
- Filled: from empty, high after LEVEL_FULL rising edges with Fill_valve_on sampled 1.
- Drained: from full, high after LEVEL_FULL edges with Drained_valve_on sampled 1.
- Detergent_Added: high after 1+DET_CYCLES edges from the first edge its entry condition is sampled true.
- Washing_Timeout: high after WASH_CYCLES edges with Fill_valve_second_on=1. Non-contiguous cycles accumulate.
- Store_Timeout: high after STORE_CYCLES qualifying edges.

Hold and clear rules:
- All handshake outputs are levels and hold until clr.
- clr on an edge zeroes the timers and the FSM on that edge.
- clr has priority over increment in the same cycle.
- Fill valve dropping during D_DISPENSE does not abort dispensing.
- Drain valve turned on before Washing_Timeout does not advance store_cnt.
- Level at LEVEL_FULL with fill still on: holds, no wrap.
- Level at 0 with drain still on: holds, no wrap.

## Test plan
- Reset low then high; Fill_valve_on=1 for 16 cycles (defaults) -> Water_Level 0..16, Filled=1 after edge 16, Drained=0 after edge 1, Fault=0.
- Door_Lock=1, level full, fill off -> Detergent_Added=1 after 5 edges; Done pulse -> 0 on next edge.
- Fill_valve_second_on=1 for 20 cycles, 0 for 3, 1 for 12 -> Washing_Timeout=1 exactly after the 32nd on-cycle.
- After wash timeout, Drained_valve_on=1 from full -> Drained after 16 edges, Store_Timeout=1 16 edges later; Done=1 -> all timers clear, Water_Level stays 0.
- Fill and drain both on for 1 cycle -> level unchanged, Fault=1, stays 1 through Done, clears only on Reset.
- Reset pulsed mid-wash (wash_cnt=10, level=16) -> all outputs at reset values immediately, with no clock edge.

Source files
------------

// File: rtl/dish_washer_plant_sensor_if.sv
// Controller <-> plant bundle for the dish-washer plant responder.
// The controller (master) drives valve/door/done commands; the plant
// (slave) answers with sensor levels, timer handshakes and the fault flag.
interface dish_washer_plant_sensor_if #(
  parameter int LEVEL_W = 8
) ();

  // controller commands
  logic               Fill_valve_on;
  logic               Fill_valve_second_on;
  logic               Drained_valve_on;
  logic               Door_Lock;
  logic               Done;

  // plant responses
  logic               Filled;
  logic               Drained;
  logic               Detergent_Added;
  logic               Washing_Timeout;
  logic               Store_Timeout;
  logic [LEVEL_W-1:0] Water_Level;
  logic               Fault;

  modport master (
    output Fill_valve_on,
    output Fill_valve_second_on,
    output Drained_valve_on,
    output Door_Lock,
    output Done,
    input  Filled,
    input  Drained,
    input  Detergent_Added,
    input  Washing_Timeout,
    input  Store_Timeout,
    input  Water_Level,
    input  Fault
  );

  modport slave (
    input  Fill_valve_on,
    input  Fill_valve_second_on,
    input  Drained_valve_on,
    input  Door_Lock,
    input  Done,
    output Filled,
    output Drained,
    output Detergent_Added,
    output Washing_Timeout,
    output Store_Timeout,
    output Water_Level,
    output Fault
  );

endinterface

// File: rtl/dish_washer_plant_sensor.sv
// Plant-side responder for the dish-washer sequencing controller.
// Models tank level, detergent dispenser, wash timer and store/dry timer,
// and raises a sticky fault when the controller misuses the plant.
// Every handshake output is a decode of a register, so outputs never
// depend combinationally on the controller's commands.
module dish_washer_plant_sensor #(
  parameter int LEVEL_W      = 8,
  parameter int LEVEL_FULL   = 16,
  parameter int CNT_W        = 16,
  parameter int DET_CYCLES   = 4,
  parameter int WASH_CYCLES  = 32,
  parameter int STORE_CYCLES = 16
) (
  input logic                         Clock,
  input logic                         Reset,
  dish_washer_plant_sensor_if.slave   bus
);

  localparam logic [LEVEL_W-1:0] LEVEL_FULL_V = LEVEL_W'(LEVEL_FULL);
  localparam logic [LEVEL_W-1:0] LEVEL_ZERO   = {LEVEL_W{1'b0}};
  localparam logic [LEVEL_W-1:0] LEVEL_ONE    = LEVEL_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0]   DET_V        = CNT_W'(DET_CYCLES);
  localparam logic [CNT_W-1:0]   WASH_V       = CNT_W'(WASH_CYCLES);
  localparam logic [CNT_W-1:0]   STORE_V      = CNT_W'(STORE_CYCLES);

  localparam logic [1:0] D_IDLE     = 2'd0;
  localparam logic [1:0] D_DISPENSE = 2'd1;
  localparam logic [1:0] D_DONE     = 2'd2;

  logic [LEVEL_W-1:0] level_r;
  logic [LEVEL_W-1:0] level_next_s;
  logic [1:0]         det_state_r;
  logic [1:0]         det_state_next_s;
  logic [CNT_W-1:0]   det_cnt_r;
  logic [CNT_W-1:0]   det_cnt_next_s;
  logic [CNT_W-1:0]   wash_cnt_r;
  logic [CNT_W-1:0]   store_cnt_r;
  logic               fault_r;

  logic clr_s;
  logic both_valves_s;
  logic filled_s;
  logic drained_s;
  logic wash_timeout_s;
  logic store_timeout_s;
  logic store_step_s;

  // Done or an unlocked door means no cycle is running: timers and FSM clear.
  assign clr_s         = bus.Done | ~bus.Door_Lock;
  assign both_valves_s = bus.Fill_valve_on & bus.Drained_valve_on;

  assign filled_s        = (level_r == LEVEL_FULL_V);
  assign drained_s       = (level_r == LEVEL_ZERO);
  assign wash_timeout_s  = (wash_cnt_r == WASH_V);
  assign store_timeout_s = (store_cnt_r == STORE_V);

  // Store timer only advances while the tank sits empty, drain still open,
  // after the wash has finished.
  assign store_step_s = drained_s & bus.Drained_valve_on & wash_timeout_s;

  // Saturating tank level: fill counts up to full, drain counts down to empty,
  // conflicting valves freeze the level.
  always_comb begin
    level_next_s = level_r;
    if (both_valves_s) begin
      level_next_s = level_r;
    end else if (bus.Fill_valve_on) begin
      if (level_r < LEVEL_FULL_V) begin
        level_next_s = level_r + LEVEL_ONE;
      end else begin
        level_next_s = level_r;
      end
    end else if (bus.Drained_valve_on) begin
      if (level_r != LEVEL_ZERO) begin
        level_next_s = level_r - LEVEL_ONE;
      end else begin
        level_next_s = level_r;
      end
    end else begin
      level_next_s = level_r;
    end
  end

  // Tank level register; deliberately untouched by the clear condition.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      level_r <= LEVEL_ZERO;
    end else begin
      level_r <= level_next_s;
    end
  end

  // Detergent dispenser next-state: starts once the tank is full and the
  // fill valve has closed, dispenses for DET_CYCLES cycles, then latches done.
  always_comb begin
    det_state_next_s = det_state_r;
    det_cnt_next_s   = det_cnt_r;
    if (clr_s) begin
      det_state_next_s = D_IDLE;
      det_cnt_next_s   = CNT_ZERO;
    end else begin
      case (det_state_r)
        D_IDLE: begin
          if (bus.Door_Lock && filled_s && !bus.Fill_valve_on) begin
            det_state_next_s = D_DISPENSE;
            det_cnt_next_s   = DET_V;
          end else begin
            det_state_next_s = D_IDLE;
            det_cnt_next_s   = CNT_ZERO;
          end
        end
        D_DISPENSE: begin
          // Fill valve reopening here does not abort the dispense.
          if (det_cnt_r <= CNT_ONE) begin
            det_state_next_s = D_DONE;
            det_cnt_next_s   = CNT_ZERO;
          end else begin
            det_state_next_s = D_DISPENSE;
            det_cnt_next_s   = det_cnt_r - CNT_ONE;
          end
        end
        D_DONE: begin
          det_state_next_s = D_DONE;
          det_cnt_next_s   = CNT_ZERO;
        end
        default: begin
          det_state_next_s = D_IDLE;
          det_cnt_next_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // Detergent FSM state and dispense down-counter.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      det_state_r <= D_IDLE;
      det_cnt_r   <= CNT_ZERO;
    end else begin
      det_state_r <= det_state_next_s;
      det_cnt_r   <= det_cnt_next_s;
    end
  end

  // Wash timer: accumulates (possibly non-contiguous) wash-valve cycles,
  // saturating at WASH_CYCLES; clear wins over increment.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wash_cnt_r <= CNT_ZERO;
    end else if (clr_s) begin
      wash_cnt_r <= CNT_ZERO;
    end else if (bus.Fill_valve_second_on && !wash_timeout_s) begin
      wash_cnt_r <= wash_cnt_r + CNT_ONE;
    end else begin
      wash_cnt_r <= wash_cnt_r;
    end
  end

  // Store timer: counts qualifying drained cycles after the wash, saturating.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      store_cnt_r <= CNT_ZERO;
    end else if (clr_s) begin
      store_cnt_r <= CNT_ZERO;
    end else if (store_step_s && !store_timeout_s) begin
      store_cnt_r <= store_cnt_r + CNT_ONE;
    end else begin
      store_cnt_r <= store_cnt_r;
    end
  end

  // Sticky misuse flag: conflicting valves, or door unlocked with water in
  // the tank. Only the hard reset clears it.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      fault_r <= 1'b0;
    end else if (both_valves_s || (!bus.Door_Lock && (level_r != LEVEL_ZERO))) begin
      fault_r <= 1'b1;
    end else begin
      fault_r <= fault_r;
    end
  end

  assign bus.Water_Level     = level_r;
  assign bus.Filled          = filled_s;
  assign bus.Drained         = drained_s;
  assign bus.Detergent_Added = (det_state_r == D_DONE);
  assign bus.Washing_Timeout = wash_timeout_s;
  assign bus.Store_Timeout   = store_timeout_s;
  assign bus.Fault           = fault_r;

endmodule

// File: tb/tb_dish_washer_plant_sensor.sv
// Directed bench for dish_washer_plant_sensor with default parameters.
// Inputs change #1 after a rising edge; outputs are sampled there too.
module tb_dish_washer_plant_sensor;

  logic Clock;
  logic Reset;
  int   checks;
  int   errors;

  dish_washer_plant_sensor_if #(.LEVEL_W(8)) bus ();

  dish_washer_plant_sensor dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic apply_reset();
    Reset = 1'b0;
    #3;
    step();
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    bus.Fill_valve_on = 1'b0;
    bus.Fill_valve_second_on = 1'b0;
    bus.Drained_valve_on = 1'b0;
    bus.Door_Lock = 1'b0;
    bus.Done = 1'b0;
    Reset = 1'b0;
    #3;
    checks++;
    if (bus.Water_Level !== 8'd0) begin
      errors++; $display("FAIL reset_level: got %0d want 0", bus.Water_Level);
    end
    checks++;
    if ({bus.Drained, bus.Filled, bus.Detergent_Added, bus.Washing_Timeout,
         bus.Store_Timeout, bus.Fault} !== 6'b100000) begin
      errors++; $display("FAIL reset_flags: got %b want 100000",
        {bus.Drained, bus.Filled, bus.Detergent_Added, bus.Washing_Timeout,
         bus.Store_Timeout, bus.Fault});
    end
    step();
    Reset = 1'b1;
  endtask

  task automatic test_fill();
    bus.Door_Lock = 1'b1;
    bus.Fill_valve_on = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      checks++;
      if (bus.Water_Level !== 8'(i)) begin
        errors++; $display("FAIL fill_level[%0d]: got %0d want %0d", i, bus.Water_Level, i);
      end
      checks++;
      if (bus.Drained !== 1'b0) begin
        errors++; $display("FAIL fill_drained[%0d]: got %b want 0", i, bus.Drained);
      end
      checks++;
      if (bus.Filled !== (i == 16)) begin
        errors++; $display("FAIL fill_filled[%0d]: got %b want %b", i, bus.Filled, (i == 16));
      end
    end
    // fill left on at full: must saturate
    step();
    checks++;
    if (bus.Water_Level !== 8'd16) begin
      errors++; $display("FAIL fill_saturate: got %0d want 16", bus.Water_Level);
    end
    checks++;
    if (bus.Fault !== 1'b0) begin
      errors++; $display("FAIL fill_fault: got %b want 0", bus.Fault);
    end
  endtask

  task automatic test_detergent();
    bus.Fill_valve_on = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      // drop... reopen fill mid-dispense: must not abort
      if (i == 2) bus.Fill_valve_on = 1'b1;
      if (i == 3) bus.Fill_valve_on = 1'b0;
      checks++;
      if (bus.Detergent_Added !== (i >= 5)) begin
        errors++; $display("FAIL det_added[%0d]: got %b want %b", i, bus.Detergent_Added, (i >= 5));
      end
    end
    bus.Done = 1'b1;
    step();
    bus.Done = 1'b0;
    checks++;
    if (bus.Detergent_Added !== 1'b0) begin
      errors++; $display("FAIL det_clear: got %b want 0", bus.Detergent_Added);
    end
  endtask

  task automatic test_wash();
    int on_cnt;
    on_cnt = 0;
    for (int k = 0; k < 37; k++) begin
      bus.Fill_valve_second_on = (k < 20 || k >= 23) ? 1'b1 : 1'b0;
      if (k < 20 || k >= 23) on_cnt++;
      step();
      checks++;
      if (bus.Washing_Timeout !== (on_cnt >= 32)) begin
        errors++; $display("FAIL wash_timeout[%0d]: got %b want %b", k, bus.Washing_Timeout, (on_cnt >= 32));
      end
    end
    bus.Fill_valve_second_on = 1'b0;
  endtask

  task automatic test_store();
    bus.Drained_valve_on = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      checks++;
      if (bus.Water_Level !== 8'(16 - i) || bus.Drained !== (i == 16)) begin
        errors++; $display("FAIL drain[%0d]: got level %0d drained %b want %0d %b",
          i, bus.Water_Level, bus.Drained, 16 - i, (i == 16));
      end
    end
    for (int j = 1; j <= 17; j++) begin
      step();
      checks++;
      if (bus.Store_Timeout !== (j >= 16)) begin
        errors++; $display("FAIL store_timeout[%0d]: got %b want %b", j, bus.Store_Timeout, (j >= 16));
      end
    end
    checks++;
    if (bus.Water_Level !== 8'd0) begin
      errors++; $display("FAIL drain_floor: got %0d want 0", bus.Water_Level);
    end
    bus.Done = 1'b1;
    step();
    bus.Done = 1'b0;
    checks++;
    if ({bus.Washing_Timeout, bus.Store_Timeout, bus.Detergent_Added, bus.Drained} !== 4'b0001
        || bus.Water_Level !== 8'd0) begin
      errors++; $display("FAIL done_clear: got wt/st/det/drn %b level %0d want 0001 0",
        {bus.Washing_Timeout, bus.Store_Timeout, bus.Detergent_Added, bus.Drained}, bus.Water_Level);
    end
    // drain still on, empty, but no wash timeout: store must not advance
    for (int j = 0; j < 20; j++) step();
    checks++;
    if (bus.Store_Timeout !== 1'b0) begin
      errors++; $display("FAIL store_needs_wash: got %b want 0", bus.Store_Timeout);
    end
    bus.Drained_valve_on = 1'b0;
  endtask

  task automatic test_fault();
    bus.Fill_valve_on = 1'b1;
    for (int i = 0; i < 4; i++) step();
    bus.Drained_valve_on = 1'b1;
    step();
    bus.Fill_valve_on = 1'b0;
    bus.Drained_valve_on = 1'b0;
    checks++;
    if (bus.Water_Level !== 8'd4 || bus.Fault !== 1'b1) begin
      errors++; $display("FAIL both_valves: got level %0d fault %b want 4 1", bus.Water_Level, bus.Fault);
    end
    bus.Done = 1'b1;
    step();
    step();
    bus.Done = 1'b0;
    step();
    checks++;
    if (bus.Fault !== 1'b1) begin
      errors++; $display("FAIL fault_sticky: got %b want 1", bus.Fault);
    end
  endtask

  task automatic test_reset_mid_wash();
    bus.Fill_valve_on = 1'b1;
    for (int i = 0; i < 16; i++) step();
    bus.Fill_valve_on = 1'b0;
    bus.Fill_valve_second_on = 1'b1;
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (bus.Water_Level !== 8'd16 || bus.Detergent_Added !== 1'b1) begin
      errors++; $display("FAIL pre_reset: got level %0d det %b want 16 1", bus.Water_Level, bus.Detergent_Added);
    end
    #2;
    Reset = 1'b0;
    #1;
    checks++;
    if (bus.Water_Level !== 8'd0) begin
      errors++; $display("FAIL async_reset_level: got %0d want 0", bus.Water_Level);
    end
    checks++;
    if ({bus.Drained, bus.Filled, bus.Detergent_Added, bus.Washing_Timeout,
         bus.Store_Timeout, bus.Fault} !== 6'b100000) begin
      errors++; $display("FAIL async_reset_flags: got %b want 100000",
        {bus.Drained, bus.Filled, bus.Detergent_Added, bus.Washing_Timeout,
         bus.Store_Timeout, bus.Fault});
    end
    bus.Fill_valve_second_on = 1'b0;
    step();
    Reset = 1'b1;
    // wash counter must really be back at 0: 31 more cycles is not enough
    bus.Fill_valve_second_on = 1'b1;
    for (int i = 0; i < 31; i++) step();
    checks++;
    if (bus.Washing_Timeout !== 1'b0) begin
      errors++; $display("FAIL wash_after_reset31: got %b want 0", bus.Washing_Timeout);
    end
    step();
    bus.Fill_valve_second_on = 1'b0;
    checks++;
    if (bus.Washing_Timeout !== 1'b1) begin
      errors++; $display("FAIL wash_after_reset32: got %b want 1", bus.Washing_Timeout);
    end
  endtask

  task automatic test_door_fault();
    apply_reset();
    bus.Door_Lock = 1'b1;
    bus.Fill_valve_on = 1'b1;
    step();
    step();
    bus.Fill_valve_on = 1'b0;
    checks++;
    if (bus.Fault !== 1'b0) begin
      errors++; $display("FAIL door_pre: got %b want 0", bus.Fault);
    end
    bus.Door_Lock = 1'b0;
    step();
    checks++;
    if (bus.Fault !== 1'b1 || bus.Water_Level !== 8'd2) begin
      errors++; $display("FAIL door_open_fault: got fault %b level %0d want 1 2", bus.Fault, bus.Water_Level);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fill();
    test_detergent();
    test_wash();
    test_store();
    test_fault();
    test_reset_mid_wash();
    test_door_fault();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
